// File: rtl/intr_pulse_ctrl.sv
// Multi-channel interrupt pulse controller: synchronises request inputs, latches press edges as
// pending and issues one fixed-length interrupt pulse per pending channel, lowest index first.
module intr_pulse_ctrl #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned PULSE_LEN = 6,
  localparam int unsigned ID_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] press_i,
  input  logic [NUM_CH-1:0] mask_i,
  output logic              intr_o,
  output logic [ID_W-1:0]   intr_id_o,
  output logic [NUM_CH-1:0] pending_o
);

  localparam int unsigned CntW = $clog2(PULSE_LEN + 1);

  typedef enum logic {StIdle, StPulse} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]   id_q, id_d, grant_id;
  logic [NUM_CH-1:0] sync1_q, sync2_q, armed_q;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] press_evt, req, grant_oh, grant;
  logic              grant_vld;

  // A channel re-arms on any cycle its synchronised input is low.
  assign press_evt = sync2_q & armed_q;
  assign req       = pending_q & ~mask_i;
  assign grant_oh  = req & (~req + NUM_CH'(1));
  assign grant_vld = |req;

  always_comb begin
    grant_id = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (req[i]) grant_id = ID_W'(i);
    end
  end

  // Set wins over the service clear in the same cycle.
  assign pending_d = (pending_q & ~grant) | (press_evt & ~mask_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      armed_q   <= '0;
      pending_q <= '0;
    end else begin
      sync1_q   <= press_i;
      sync2_q   <= sync1_q;
      armed_q   <= ~sync2_q;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    grant   = '0;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          state_d = StPulse;
          cnt_d   = CntW'(PULSE_LEN - 1);
          id_d    = grant_id;
          grant   = grant_oh;
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    intr_o    = (state_q == StPulse);
    intr_id_o = id_q;
    pending_o = pending_q;
  end

endmodule

// File: tb/tb_intr_pulse_ctrl.sv
// Scoreboard bench for intr_pulse_ctrl: a press-edge/priority reference model predicts pulses,
// a monitor checks each observed pulse; a second small instance covers the 1-channel/1-cycle case.
module tb_intr_pulse_ctrl;

  localparam int NCH  = 4;
  localparam int PLEN = 6;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic [NCH-1:0] press = '0;
  logic [NCH-1:0] mask = '0;
  logic           intr;
  logic [1:0]     intr_id;
  logic [NCH-1:0] pending;

  logic [0:0] press_b = '0;
  logic [0:0] mask_b = '0;
  logic       intr_b;
  logic [0:0] id_b;
  logic [0:0] pend_b;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk_i = ~clk_i;

  intr_pulse_ctrl #(.NUM_CH(NCH), .PULSE_LEN(PLEN)) u_dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .press_i   (press),
    .mask_i    (mask),
    .intr_o    (intr),
    .intr_id_o (intr_id),
    .pending_o (pending)
  );

  intr_pulse_ctrl #(.NUM_CH(1), .PULSE_LEN(1)) u_dut_b (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .press_i   (press_b),
    .mask_i    (mask_b),
    .intr_o    (intr_b),
    .intr_id_o (id_b),
    .pending_o (pend_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request is a rising edge of the input as seen two clocks later; pending
  // requests are served one at a time, lowest unmasked index first, each for PLEN cycles, and a
  // new service can only begin from a cycle with no pulse in progress.
  int             exp_q[$];
  logic [NCH-1:0] m_s1, m_s, m_s_last, m_pend, m_evt, m_req;
  int             m_rem;
  bit             m_found;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_s1 = '0; m_s = '0; m_s_last = '1; m_pend = '0; m_rem = 0;
      exp_q.delete();
    end else begin
      m_evt = m_s & ~m_s_last;
      m_req = m_pend & ~mask;
      if (m_rem > 0) begin
        m_rem--;
      end else begin
        m_found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
          if (!m_found && m_req[i]) begin
            m_found   = 1'b1;
            m_pend[i] = 1'b0;
            m_rem     = PLEN;
            exp_q.push_back(i);
          end
        end
      end
      m_pend   = m_pend | (m_evt & ~mask);
      m_s_last = m_s;
      m_s      = m_s1;
      m_s1     = press;
    end
  end

  // Per-cycle state comparison against the model.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      chk("pending", int'(pending), int'(m_pend));
      chk("intr_level", int'(intr), int'(m_rem > 0));
    end
  end

  // Monitor: each observed pulse is matched against the next expected service.
  bit in_pulse = 1'b0;
  int plen     = 0;
  int cur_id   = 0;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      in_pulse = 1'b0;
    end else if (intr && !in_pulse) begin
      in_pulse = 1'b1;
      plen     = 1;
      chk("sb_nonempty", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        cur_id = exp_q.pop_front();
        chk("intr_id", int'(intr_id), cur_id);
      end
    end else if (intr) begin
      plen++;
      chk("intr_id_hold", int'(intr_id), cur_id);
    end else if (in_pulse) begin
      in_pulse = 1'b0;
      pulses++;
      chk("pulse_len", plen, PLEN);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  logic [11:0] bhist;
  logic [11:0] exp_b;
  int          p0;
  bit          seen;

  initial begin
    // Reset and idle
    cycles(3);
    chk("rst_intr", int'(intr), 0);
    chk("rst_id", int'(intr_id), 0);
    chk("rst_pending", int'(pending), 0);
    rst_ni = 1'b1;
    cycles(20);
    chk("idle_pulses", pulses, 0);

    // Single long press on channel 2: exactly one pulse
    p0 = pulses;
    press[2] = 1'b1;
    cycles(30);
    chk("single_press_pulses", pulses - p0, 1);
    press[2] = 1'b0;
    cycles(3);
    press[2] = 1'b1;
    cycles(12);
    press[2] = 1'b0;
    chk("repress_pulses", pulses - p0, 2);
    cycles(5);

    // Priority: channels 1 and 3 together
    p0 = pulses;
    press[1] = 1'b1; press[3] = 1'b1;
    cycles(4);
    press = '0;
    cycles(20);
    chk("priority_pulses", pulses - p0, 2);

    // Masked channel 0 toggling: dropped
    p0 = pulses;
    mask[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      press[0] = ~press[0];
      cycles(2);
    end
    press[0] = 1'b0;
    cycles(4);
    mask[0] = 1'b0;
    cycles(10);
    chk("masked_pulses", pulses - p0, 0);

    // Pending held under mask, served after unmask
    press[1] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_i);
      if (pending[1]) seen = 1'b1;
    end
    chk("wait_pending1", int'(seen), 1);
    mask[1] = 1'b1;
    press[1] = 1'b0;
    cycles(10);
    chk("masked_hold_intr", int'(intr), 0);
    mask[1] = 1'b0;
    @(negedge clk_i);
    chk("unmask_intr", int'(intr), 1);
    chk("unmask_id", int'(intr_id), 1);
    cycles(12);

    // Random stimulus
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(7) == 0) press[c] = ~press[c];
      end
      if ($urandom_range(15) == 0) mask = NCH'($urandom_range(15));
      @(negedge clk_i);
    end
    press = '0;
    mask = '0;
    cycles(60);
    chk("drained", exp_q.size(), 0);

    // Reset in pulse cycle 3
    press[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_i);
      if (intr) seen = 1'b1;
    end
    chk("wait_intr", int'(seen), 1);
    cycles(2);
    #1 rst_ni = 1'b0;
    #1;
    chk("midrst_intr", int'(intr), 0);
    chk("midrst_pending", int'(pending), 0);
    cycles(2);
    press[0] = 1'b0;
    cycles(1);
    rst_ni = 1'b1;
    p0 = pulses;
    cycles(20);
    chk("post_rst_pulses", pulses - p0, 0);

    // One channel, one-cycle pulses: re-press lands while the first pulse is pending/served
    exp_b = 12'b0000_0010_1000;
    @(negedge clk_i); press_b = 1'b1;
    @(negedge clk_i); bhist[0] = intr_b; press_b = 1'b0;
    @(negedge clk_i); bhist[1] = intr_b; press_b = 1'b1;
    @(negedge clk_i); bhist[2] = intr_b; press_b = 1'b0;
    for (int i = 3; i < 12; i++) begin
      @(negedge clk_i);
      bhist[i] = intr_b;
    end
    chk("b_pattern", int'(bhist), int'(exp_b));
    chk("b_id", int'(id_b), 0);
    chk("b_pending", int'(pend_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
